// File: rtl/dcsk_tx_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// dcsk_tx_scheduler_pkg
//   Shared types for the DCSK transmit scheduler.
//   sf_t          : spreading factor code, as seen by the tx and the demodulator
//   sched_state_t : scheduler FSM states
//   sched_entry_t : one queued request ({sf, msg})
// ---------------------------------------------------------------------------
package dcsk_tx_scheduler_pkg;

    typedef enum logic [1:0] {
        SF4  = 2'd0,
        SF8  = 2'd1,
        SF16 = 2'd2,
        SF32 = 2'd3
    } sf_t;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        LOAD       = 3'd1,
        ISSUE      = 3'd2,
        WAIT_START = 3'd3,
        WAIT_DONE  = 3'd4,
        GAP        = 3'd5
    } sched_state_t;

    localparam int MSG_W = 32;
    localparam int SF_W  = $bits(sf_t);

    typedef struct packed {
        sf_t              sf;
        logic [MSG_W-1:0] msg;
    } sched_entry_t;

    localparam int ENTRY_W = $bits(sched_entry_t);

endpackage

// File: rtl/dcsk_tx_scheduler_fifo.sv
// ---------------------------------------------------------------------------
// sched_fifo
//   Synchronous request queue for the DCSK tx scheduler. The head entry is
//   always visible on o_data; a pop advances to the next entry.
// Ports
//   i_clk, i_arst_n : clock, async active-low reset (flushes the queue)
//   i_push, i_data  : write an entry (ignored when full)
//   i_pop           : drop the head entry (ignored when empty)
//   o_data          : head entry
//   o_full, o_empty : occupancy flags
//   o_count         : number of stored entries (0..DEPTH)
// ---------------------------------------------------------------------------
module sched_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 34
) (
    input  logic                     i_clk,
    input  logic                     i_arst_n,
    input  logic                     i_push,
    input  logic [W-1:0]             i_data,
    input  logic                     i_pop,
    output logic [W-1:0]             o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign o_full  = (count == (AW+1)'(DEPTH));
    assign o_empty = (count == '0);
    assign o_count = count;
    assign o_data  = mem[rd_ptr];

    assign do_push = i_push && !o_full;
    assign do_pop  = i_pop && !o_empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: the pointers alone define what is valid.
    always_ff @(posedge i_clk) begin
        if (do_push) mem[wr_ptr] <= i_data;
    end

endmodule

// File: rtl/dcsk_tx_scheduler.sv
// ---------------------------------------------------------------------------
// dcsk_tx_scheduler
//   Sequences the DCSK transmitter: queues (msg, SF) requests, reloads the
//   chaos seed between frames, issues one send per message, waits for the
//   frame to finish and then inserts a programmable idle gap.
// Ports
//   i_clk, i_arst_n   : clock, async active-low reset
//   i_enable          : 0 lets the current frame finish, then parks in IDLE
//   i_req_valid/o_req_ready, i_req_msg, i_req_sf : request handshake
//   i_seed, i_seed_wr : new seed value and its write strobe
//   i_gap_len         : idle cycles after each frame (sampled at frame end)
//   o_tx_seed, o_tx_load_seed, o_tx_send, o_tx_msg, o_tx_sf : to the tx
//   i_tx_is_sending   : tx busy flag
//   o_busy, o_level, o_sent_cnt, o_err_timeout : status
// ---------------------------------------------------------------------------
module dcsk_tx_scheduler
    import dcsk_tx_scheduler_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int SEED_W     = 32,
    parameter int GAP_W      = 4,
    parameter int START_TO   = 8
) (
    input  logic                         i_clk,
    input  logic                         i_arst_n,
    input  logic                         i_enable,
    input  logic                         i_req_valid,
    output logic                         o_req_ready,
    input  logic [MSG_W-1:0]             i_req_msg,
    input  logic [SF_W-1:0]              i_req_sf,
    input  logic [SEED_W-1:0]            i_seed,
    input  logic                         i_seed_wr,
    input  logic [GAP_W-1:0]             i_gap_len,
    output logic [SEED_W-1:0]            o_tx_seed,
    output logic                         o_tx_load_seed,
    output logic                         o_tx_send,
    output logic [MSG_W-1:0]             o_tx_msg,
    output logic [SF_W-1:0]              o_tx_sf,
    input  logic                         i_tx_is_sending,
    output logic                         o_busy,
    output logic [$clog2(FIFO_DEPTH):0]  o_level,
    output logic [15:0]                  o_sent_cnt,
    output logic                         o_err_timeout
);

    localparam int TMR_W = $clog2(START_TO + 1);

    sched_state_t      state;
    sched_state_t      state_next;

    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_pop;
    logic              fifo_push;
    logic [ENTRY_W-1:0] fifo_rdata;
    sched_entry_t      push_entry;
    sched_entry_t      head_entry;

    logic              seed_pending;
    logic [TMR_W-1:0]  timer;
    logic [GAP_W-1:0]  gap_cnt;

    logic              load_fire;
    logic              send_fire;
    logic              timeout_fire;
    logic              done_fire;

    logic [SEED_W-1:0] tx_seed;
    logic              tx_load_seed;
    logic              tx_send;
    logic [MSG_W-1:0]  tx_msg;
    sf_t               tx_sf;
    logic [15:0]       sent_cnt;
    logic              err_timeout;

    assign fifo_push  = i_req_valid && o_req_ready;
    assign push_entry = '{sf: sf_t'(i_req_sf), msg: i_req_msg};
    assign head_entry = sched_entry_t'(fifo_rdata);

    sched_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (ENTRY_W)
    ) u_fifo (
        .i_clk    (i_clk),
        .i_arst_n (i_arst_n),
        .i_push   (fifo_push),
        .i_data   (push_entry),
        .i_pop    (fifo_pop),
        .o_data   (fifo_rdata),
        .o_full   (fifo_full),
        .o_empty  (fifo_empty),
        .o_count  (o_level)
    );

    // Seed reloads are only started from IDLE, so a write that lands during
    // a frame waits until the frame and its gap are over.
    always_comb begin
        state_next   = state;
        fifo_pop     = 1'b0;
        load_fire    = 1'b0;
        send_fire    = 1'b0;
        timeout_fire = 1'b0;
        done_fire    = 1'b0;
        case (state)
            IDLE: begin
                if (seed_pending) begin
                    state_next = LOAD;
                end else if (i_enable && !fifo_empty) begin
                    state_next = ISSUE;
                    fifo_pop   = 1'b1;
                end
            end
            LOAD: begin
                load_fire  = 1'b1;
                state_next = IDLE;
            end
            ISSUE: begin
                send_fire  = 1'b1;
                state_next = WAIT_START;
            end
            WAIT_START: begin
                if (i_tx_is_sending) begin
                    state_next = WAIT_DONE;
                end else if (timer == TMR_W'(START_TO - 1)) begin
                    timeout_fire = 1'b1;
                    state_next   = GAP;
                end
            end
            WAIT_DONE: begin
                if (!i_tx_is_sending) begin
                    done_fire  = 1'b1;
                    state_next = GAP;
                end
            end
            GAP: begin
                // A zero gap still spends one cycle here.
                if (gap_cnt <= GAP_W'(1)) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            state        <= IDLE;
            seed_pending <= 1'b0;
            timer        <= '0;
            gap_cnt      <= '0;
            tx_seed      <= '0;
            tx_load_seed <= 1'b0;
            tx_send      <= 1'b0;
            tx_msg       <= '0;
            tx_sf        <= SF4;
            sent_cnt     <= '0;
            err_timeout  <= 1'b0;
        end else begin
            state        <= state_next;
            tx_load_seed <= load_fire;
            tx_send      <= send_fire;

            if (fifo_pop) begin
                tx_msg <= head_entry.msg;
                tx_sf  <= head_entry.sf;
            end

            // A write in the same cycle as a reload keeps the flag set, so
            // the newer seed still gets loaded.
            if (i_seed_wr) begin
                tx_seed      <= i_seed;
                seed_pending <= 1'b1;
            end else if (load_fire) begin
                seed_pending <= 1'b0;
            end

            // timer counts cycles spent in WAIT_START, from the send pulse on.
            if (send_fire) begin
                timer <= '0;
            end else if (state == WAIT_START) begin
                timer <= timer + 1'b1;
            end

            if (timeout_fire) err_timeout <= 1'b1;
            if (done_fire)    sent_cnt    <= sent_cnt + 1'b1;

            if (timeout_fire || done_fire) begin
                gap_cnt <= i_gap_len;
            end else if (state == GAP && gap_cnt > GAP_W'(1)) begin
                gap_cnt <= gap_cnt - 1'b1;
            end
        end
    end

    assign o_req_ready    = !fifo_full;
    assign o_busy         = (state != IDLE) || !fifo_empty;
    assign o_tx_seed      = tx_seed;
    assign o_tx_load_seed = tx_load_seed;
    assign o_tx_send      = tx_send;
    assign o_tx_msg       = tx_msg;
    assign o_tx_sf        = tx_sf;
    assign o_sent_cnt     = sent_cnt;
    assign o_err_timeout  = err_timeout;

endmodule

// File: tb/tb_dcsk_tx_scheduler.sv
// ---------------------------------------------------------------------------
// tb_dcsk_tx_scheduler
//   Drives dcsk_tx_scheduler with directed and random traffic. A small tx
//   model answers o_tx_send with a busy window; a scoreboard of accepted
//   requests and the seed write history define what each send, reload and
//   frame completion must look like.
// ---------------------------------------------------------------------------
module tb_dcsk_tx_scheduler;
    import dcsk_tx_scheduler_pkg::*;

    localparam int FIFO_DEPTH = 4;
    localparam int SEED_W     = 32;
    localparam int GAP_W      = 4;
    localparam int START_TO   = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_enable = 1'b0;
    logic        i_req_valid = 1'b0;
    logic        o_req_ready;
    logic [31:0] i_req_msg = '0;
    logic [1:0]  i_req_sf = '0;
    logic [31:0] i_seed = '0;
    logic        i_seed_wr = 1'b0;
    logic [3:0]  i_gap_len = '0;
    logic [31:0] o_tx_seed;
    logic        o_tx_load_seed;
    logic        o_tx_send;
    logic [31:0] o_tx_msg;
    logic [1:0]  o_tx_sf;
    logic        i_tx_is_sending = 1'b0;
    logic        o_busy;
    logic [2:0]  o_level;
    logic [15:0] o_sent_cnt;
    logic        o_err_timeout;

    always #5 clk = ~clk;

    dcsk_tx_scheduler #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .SEED_W     (SEED_W),
        .GAP_W      (GAP_W),
        .START_TO   (START_TO)
    ) dut (
        .i_clk           (clk),
        .i_arst_n        (rst_n),
        .i_enable        (i_enable),
        .i_req_valid     (i_req_valid),
        .o_req_ready     (o_req_ready),
        .i_req_msg       (i_req_msg),
        .i_req_sf        (i_req_sf),
        .i_seed          (i_seed),
        .i_seed_wr       (i_seed_wr),
        .i_gap_len       (i_gap_len),
        .o_tx_seed       (o_tx_seed),
        .o_tx_load_seed  (o_tx_load_seed),
        .o_tx_send       (o_tx_send),
        .o_tx_msg        (o_tx_msg),
        .o_tx_sf         (o_tx_sf),
        .i_tx_is_sending (i_tx_is_sending),
        .o_busy          (o_busy),
        .o_level         (o_level),
        .o_sent_cnt      (o_sent_cnt),
        .o_err_timeout   (o_err_timeout)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference state
    logic [33:0] sb_q[$];
    logic [31:0] exp_seed = '0;
    int          pend_n = -1;
    int          last_wr_n = -100;
    int          cyc = 0;
    bit          in_frame = 0;
    logic [31:0] cur_msg = '0;
    logic [1:0]  cur_sf = '0;
    int          frames_done = 0;
    int          sends_seen = 0;
    int          loads_seen = 0;
    int          last_send_n = -1;
    int          last_load_n = -1;
    int          last_done_n = -1;
    int          load_after_done = -1;
    bit          spacing_armed = 0;
    int          exp_spacing = 0;
    logic        prev_send = 0, prev_load = 0, prev_err = 0;
    logic [15:0] prev_cnt = '0;

    // tx model
    int tx_st = 0, tx_delay = 0, tx_len = 0, force_len = 0;
    bit tx_dead = 0;

    task automatic check_output(input string tag, input logic [63:0] observed,
                                input logic [63:0] expected);
        n_checks++;
        if (observed === expected) n_pass++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    endtask

    // One clock: wait for the falling edge, judge what the last rising edge
    // produced, then let the tx model react.
    task automatic cycle();
        logic [33:0] head;
        @(negedge clk);
        cyc++;
        if (o_tx_send) begin
            check_output("send_width", 64'(prev_send), 64'(0));
            check_output("send_in_frame", 64'(in_frame), 64'(0));
            check_output("sb_nonempty", 64'(sb_q.size() > 0), 64'(1));
            if (sb_q.size() > 0) begin
                head = sb_q.pop_front();
                check_output("send_msg", 64'(o_tx_msg), 64'(head[31:0]));
                check_output("send_sf", 64'(o_tx_sf), 64'(head[33:32]));
            end
            check_output("seed_before_send", 64'(pend_n < 0 || pend_n >= cyc - 2), 64'(1));
            if (spacing_armed && last_done_n >= 0)
                check_output("gap_spacing", 64'(cyc - last_done_n), 64'(exp_spacing));
            in_frame    = 1;
            cur_msg     = o_tx_msg;
            cur_sf      = o_tx_sf;
            sends_seen++;
            last_send_n = cyc;
        end
        if (o_tx_load_seed) begin
            check_output("load_width", 64'(prev_load), 64'(0));
            check_output("load_seed_val", 64'(o_tx_seed), 64'(exp_seed));
            check_output("load_mid_frame", 64'(in_frame), 64'(0));
            check_output("load_had_pending", 64'(pend_n >= 0), 64'(1));
            pend_n          = (last_wr_n == cyc - 1) ? cyc - 1 : -1;
            loads_seen++;
            last_load_n     = cyc;
            load_after_done = cyc - last_done_n;
        end
        if (o_sent_cnt != prev_cnt) begin
            check_output("sent_cnt", 64'(o_sent_cnt), 64'(frames_done[15:0]));
            check_output("msg_held", 64'(o_tx_msg), 64'(cur_msg));
            check_output("sf_held", 64'(o_tx_sf), 64'(cur_sf));
            in_frame    = 0;
            last_done_n = cyc;
        end
        if (o_err_timeout && !prev_err) begin
            check_output("timeout_latency", 64'(cyc - last_send_n), 64'(START_TO));
            in_frame    = 0;
            last_done_n = cyc;
        end
        prev_send = o_tx_send;
        prev_load = o_tx_load_seed;
        prev_err  = o_err_timeout;
        prev_cnt  = o_sent_cnt;

        if (tx_st == 0 && o_tx_send && !tx_dead) begin
            tx_delay = $urandom_range(0, 2);
            tx_st    = 1;
        end
        if (tx_st == 1) begin
            if (tx_delay == 0) begin
                i_tx_is_sending = 1'b1;
                tx_len = (force_len > 0) ? force_len : $urandom_range(1, 6);
                tx_st  = 2;
            end else begin
                tx_delay--;
            end
        end else if (tx_st == 2) begin
            tx_len--;
            if (tx_len == 0) begin
                i_tx_is_sending = 1'b0;
                frames_done++;
                tx_st = 0;
            end
        end
    endtask

    task automatic push_req(input logic [31:0] msg, input logic [1:0] sf);
        i_req_valid = 1'b1;
        i_req_msg   = msg;
        i_req_sf    = sf;
        if (o_req_ready) sb_q.push_back({sf, msg});
        cycle();
        i_req_valid = 1'b0;
    endtask

    task automatic note_seed_write(input logic [31:0] s);
        i_seed    = s;
        i_seed_wr = 1'b1;
        exp_seed  = s;
        last_wr_n = cyc;
        if (pend_n < 0) pend_n = cyc;
    endtask

    task automatic wait_idle(input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            cycle();
            if (!o_busy && tx_st == 0) break;
        end
        check_output("idle_wait", 64'(o_busy), 64'(0));
    endtask

    task automatic check_reset_values(input string tag);
        check_output({tag, "_ready"}, 64'(o_req_ready), 64'(1));
        check_output({tag, "_send"}, 64'(o_tx_send), 64'(0));
        check_output({tag, "_load"}, 64'(o_tx_load_seed), 64'(0));
        check_output({tag, "_seed"}, 64'(o_tx_seed), 64'(0));
        check_output({tag, "_msg"}, 64'(o_tx_msg), 64'(0));
        check_output({tag, "_sf"}, 64'(o_tx_sf), 64'(SF4));
        check_output({tag, "_busy"}, 64'(o_busy), 64'(0));
        check_output({tag, "_level"}, 64'(o_level), 64'(0));
        check_output({tag, "_cnt"}, 64'(o_sent_cnt), 64'(0));
        check_output({tag, "_err"}, 64'(o_err_timeout), 64'(0));
    endtask

    task automatic apply_stimulus();
        int n0;
        int s0;
        int cnt0;

        // Reset values, then seed write together with the first request.
        #12;
        check_reset_values("reset");
        @(negedge clk);
        rst_n = 1'b1;
        i_enable = 1'b1;
        note_seed_write(32'hDEADBEEF);
        push_req(32'hA5A5_0F0F, SF4);
        i_seed_wr = 1'b0;
        wait_idle(200);
        check_output("t1_sent_cnt", 64'(o_sent_cnt), 64'(1));
        check_output("t1_load_first", 64'(last_load_n >= 0 && last_load_n < last_send_n), 64'(1));

        // Push-to-send latency from an idle, empty scheduler.
        n0 = cyc;
        s0 = sends_seen;
        push_req(32'h1357_9BDF, SF16);
        for (int i = 0; i < 10 && sends_seen == s0; i++) cycle();
        check_output("latency", 64'(last_send_n - n0), 64'(3));
        wait_idle(200);

        // Fill the queue while disabled, then drain back-to-back with gap 0.
        i_enable  = 1'b0;
        i_gap_len = 4'd0;
        push_req(32'h0000_0004, SF4);
        push_req(32'h0000_0008, SF8);
        push_req(32'h0000_0010, SF16);
        push_req(32'h0000_0020, SF32);
        check_output("full_ready", 64'(o_req_ready), 64'(0));
        check_output("full_level", 64'(o_level), 64'(4));
        s0 = sends_seen;
        push_req(32'hBAD0_BAD0, SF8);
        repeat (5) cycle();
        check_output("full_level_hold", 64'(o_level), 64'(4));
        check_output("disabled_no_send", 64'(sends_seen - s0), 64'(0));
        i_enable      = 1'b1;
        spacing_armed = 1;
        exp_spacing   = 3;
        last_done_n   = -1;
        wait_idle(300);
        spacing_armed = 0;
        check_output("t2_sb_empty", 64'(sb_q.size()), 64'(0));
        check_output("t2_sent_cnt", 64'(o_sent_cnt), 64'(6));

        // Gap of 5: completion to next send is 7 cycles.
        i_enable  = 1'b0;
        i_gap_len = 4'd5;
        push_req(32'hCAFE_0001, SF8);
        push_req(32'hCAFE_0002, SF32);
        i_enable      = 1'b1;
        spacing_armed = 1;
        exp_spacing   = 7;
        last_done_n   = -1;
        s0 = loads_seen;
        wait_idle(300);
        spacing_armed = 0;
        check_output("t3_sent_cnt", 64'(o_sent_cnt), 64'(8));

        // Seed written during WAIT_DONE waits until the gap has elapsed.
        i_enable  = 1'b0;
        i_gap_len = 4'd3;
        force_len = 6;
        push_req(32'h5EED_0001, SF4);
        push_req(32'h5EED_0002, SF16);
        i_enable = 1'b1;
        for (int i = 0; i < 20 && !i_tx_is_sending; i++) cycle();
        cycle();
        cycle();
        s0 = loads_seen;
        note_seed_write(32'h1234_5678);
        cycle();
        i_seed_wr = 1'b0;
        wait_idle(300);
        force_len = 0;
        check_output("t5_one_load", 64'(loads_seen - s0), 64'(1));
        check_output("t5_load_after_gap", 64'(load_after_done), 64'(5));
        check_output("t5_load_then_send", 64'(last_send_n > last_load_n), 64'(1));

        // Start timeout: tx never answers.
        tx_dead   = 1;
        i_gap_len = 4'd1;
        cnt0 = frames_done;
        push_req(32'hDEAD_0001, SF8);
        wait_idle(100);
        check_output("t4_err", 64'(o_err_timeout), 64'(1));
        check_output("t4_cnt_same", 64'(o_sent_cnt), 64'(cnt0));
        check_output("t4_dropped", 64'(sb_q.size()), 64'(0));
        tx_dead = 0;

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            i_enable = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 7) == 0) i_gap_len = 4'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) begin
                i_req_valid = 1'b1;
                i_req_msg   = $urandom;
                i_req_sf    = 2'($urandom_range(0, 3));
                if (o_req_ready) sb_q.push_back({i_req_sf, i_req_msg});
            end else begin
                i_req_valid = 1'b0;
            end
            if ($urandom_range(0, 24) == 0) note_seed_write($urandom);
            else i_seed_wr = 1'b0;
            cycle();
        end
        i_req_valid = 1'b0;
        i_seed_wr   = 1'b0;
        i_enable    = 1'b1;
        wait_idle(2000);
        check_output("rnd_sb_empty", 64'(sb_q.size()), 64'(0));
        check_output("rnd_level", 64'(o_level), 64'(0));
        check_output("rnd_sent_cnt", 64'(o_sent_cnt), 64'(frames_done[15:0]));
        check_output("rnd_no_pending", 64'(pend_n), 64'(-1));

        // Reset in the middle of a frame with requests still queued.
        i_enable  = 1'b0;
        i_gap_len = 4'd0;
        force_len = 6;
        push_req(32'h0600_0001, SF8);
        push_req(32'h0600_0002, SF16);
        push_req(32'h0600_0003, SF32);
        push_req(32'h0600_0004, SF4);
        i_enable = 1'b1;
        for (int i = 0; i < 20 && !i_tx_is_sending; i++) cycle();
        cycle();
        check_output("t6_queued", 64'(o_level), 64'(3));
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_values("midreset");
        sb_q.delete();
        in_frame = 0;
        tx_st = 0;
        force_len = 0;
        i_tx_is_sending = 1'b0;
        frames_done = 0;
        pend_n = -1;
        prev_send = 0;
        prev_load = 0;
        prev_err = 0;
        prev_cnt = '0;
        @(negedge clk);
        rst_n = 1'b1;
        s0 = sends_seen;
        repeat (30) cycle();
        check_output("t6_no_send", 64'(sends_seen - s0), 64'(0));
        check_output("t6_level", 64'(o_level), 64'(0));
        check_output("t6_busy", 64'(o_busy), 64'(0));
    endtask

    initial begin
        apply_stimulus();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got no end, expected end");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
